// File: rtl/gpu_mem_pkg.sv
// Shared types and default sizing for the per-thread data-memory responder.
package gpu_mem_pkg;

    localparam int DEF_NUM_CONSUMERS = 4;
    localparam int DEF_ADDR_BITS     = 8;
    localparam int DEF_DATA_BITS     = 8;
    localparam int DEF_LATENCY       = 2;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESPOND
    } mem_state_t;

    typedef enum logic {
        KIND_READ,
        KIND_WRITE
    } mem_kind_t;

endpackage

// File: rtl/data_mem_responder_rr_arbiter.sv
// Round-robin arbiter: first requesting lane at or after ptr, searching upward with wrap.
module rr_arbiter #(
    parameter int NUM_CONSUMERS = 4,
    parameter int IDX_BITS      = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1
) (
    input  logic [NUM_CONSUMERS-1:0] req,
    input  logic [IDX_BITS-1:0]      ptr,
    output logic [NUM_CONSUMERS-1:0] grant,
    output logic [IDX_BITS-1:0]      grant_idx
);

    logic found;
    int   idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int k = 0; k < NUM_CONSUMERS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_CONSUMERS) idx = idx - NUM_CONSUMERS;
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_BITS'(idx);
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: round-robin arbitration of per-lane read/write requests onto one
// array, fixed access latency, 4-phase valid/ready completion.
//   state   | meaning
//   IDLE    | no transaction; grant the next pending lane
//   WAIT    | latency countdown; access and ready on the edge the counter is 0
//   RESPOND | ready held high until the granted lane drops its valid
module data_mem_responder
    import gpu_mem_pkg::*;
#(
    parameter int NUM_CONSUMERS = DEF_NUM_CONSUMERS,
    parameter int ADDR_BITS     = DEF_ADDR_BITS,
    parameter int DATA_BITS     = DEF_DATA_BITS,
    parameter int LATENCY       = DEF_LATENCY
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic [NUM_CONSUMERS-1:0]                 mem_read_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  mem_read_address,
    output logic [NUM_CONSUMERS-1:0]                 mem_read_ready,
    output logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  mem_read_data,
    input  logic [NUM_CONSUMERS-1:0]                 mem_write_valid,
    input  logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0]  mem_write_address,
    input  logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0]  mem_write_data,
    output logic [NUM_CONSUMERS-1:0]                 mem_write_ready,
    input  logic                                     preload_valid,
    input  logic [ADDR_BITS-1:0]                     preload_address,
    input  logic [DATA_BITS-1:0]                     preload_data,
    output logic                                     busy
);

    localparam int IW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam int CW = (LATENCY > 0) ? $clog2(LATENCY + 1) : 1;

    mem_state_t                 state, state_nx;
    mem_kind_t                  g_kind, g_kind_nx;
    logic [IW-1:0]              ptr, ptr_nx;
    logic [IW-1:0]              g_idx, g_idx_nx;
    logic [CW-1:0]              cnt, cnt_nx;
    logic [ADDR_BITS-1:0]       g_addr, g_addr_nx;
    logic [DATA_BITS-1:0]       g_data, g_data_nx;
    logic [NUM_CONSUMERS-1:0]   rd_rdy_nx, wr_rdy_nx;
    logic [NUM_CONSUMERS-1:0]   req, grant;
    logic [IW-1:0]              grant_idx;
    logic                       commit_rd, commit_wr;

    logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

    always_comb begin
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            req[i] = (mem_read_valid[i] | mem_write_valid[i]) & ~mem_read_ready[i] & ~mem_write_ready[i];
        end
    end

    rr_arbiter #(
        .NUM_CONSUMERS (NUM_CONSUMERS),
        .IDX_BITS      (IW)
    ) u_arb (
        .req       (req),
        .ptr       (ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        state_nx  = state;
        ptr_nx    = ptr;
        cnt_nx    = cnt;
        g_idx_nx  = g_idx;
        g_kind_nx = g_kind;
        g_addr_nx = g_addr;
        g_data_nx = g_data;
        rd_rdy_nx = mem_read_ready;
        wr_rdy_nx = mem_write_ready;
        commit_rd = 1'b0;
        commit_wr = 1'b0;
        case (state)
            IDLE: begin
                if (|grant) begin
                    // A lane with both valids gets its read first; the write re-arbitrates later.
                    g_idx_nx  = grant_idx;
                    g_kind_nx = mem_read_valid[grant_idx] ? KIND_READ : KIND_WRITE;
                    g_addr_nx = mem_read_valid[grant_idx] ? mem_read_address[grant_idx]
                                                          : mem_write_address[grant_idx];
                    g_data_nx = mem_write_data[grant_idx];
                    cnt_nx    = CW'(LATENCY);
                    ptr_nx    = (grant_idx == IW'(NUM_CONSUMERS - 1)) ? '0 : grant_idx + IW'(1);
                    state_nx  = WAIT;
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nx = cnt - CW'(1);
                end else begin
                    if (g_kind == KIND_READ) begin
                        commit_rd        = 1'b1;
                        rd_rdy_nx[g_idx] = 1'b1;
                    end else begin
                        commit_wr        = 1'b1;
                        wr_rdy_nx[g_idx] = 1'b1;
                    end
                    state_nx = RESPOND;
                end
            end
            RESPOND: begin
                if (g_kind == KIND_READ) begin
                    if (!mem_read_valid[g_idx]) begin
                        rd_rdy_nx[g_idx] = 1'b0;
                        state_nx         = IDLE;
                    end
                end else if (!mem_write_valid[g_idx]) begin
                    wr_rdy_nx[g_idx] = 1'b0;
                    state_nx         = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            ptr             <= '0;
            cnt             <= '0;
            g_idx           <= '0;
            g_kind          <= KIND_READ;
            g_addr          <= '0;
            g_data          <= '0;
            mem_read_ready  <= '0;
            mem_write_ready <= '0;
            mem_read_data   <= '0;
        end else begin
            state           <= state_nx;
            ptr             <= ptr_nx;
            cnt             <= cnt_nx;
            g_idx           <= g_idx_nx;
            g_kind          <= g_kind_nx;
            g_addr          <= g_addr_nx;
            g_data          <= g_data_nx;
            mem_read_ready  <= rd_rdy_nx;
            mem_write_ready <= wr_rdy_nx;
            if (commit_rd) mem_read_data[g_idx] <= mem[g_addr];
        end
    end

    // Array is never reset; a same-edge consumer write overrides the preload.
    always_ff @(posedge clk) begin
        if (preload_valid) mem[preload_address] <= preload_data;
        if (commit_wr)     mem[g_addr]          <= g_data;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder: directed scenarios plus randomized per-lane traffic.
module tb_data_mem_responder;

    localparam int N  = 4;
    localparam int AB = 8;
    localparam int DB = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic [N-1:0]          rv, rr, wv, wr;
    logic [N-1:0][AB-1:0]  ra, wa;
    logic [N-1:0][DB-1:0]  rd, wd;
    logic                  pv;
    logic [AB-1:0]         pa;
    logic [DB-1:0]         pd;
    logic                  busy;

    logic [N-1:0]          rv0, rr0, wv0, wr0;
    logic [N-1:0][AB-1:0]  ra0, wa0;
    logic [N-1:0][DB-1:0]  rd0, wd0;
    logic                  pv0;
    logic [AB-1:0]         pa0;
    logic [DB-1:0]         pd0;
    logic                  busy0;

    data_mem_responder #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .LATENCY(2)) u_dut (
        .clk(clk), .reset(rst_n),
        .mem_read_valid(rv), .mem_read_address(ra), .mem_read_ready(rr), .mem_read_data(rd),
        .mem_write_valid(wv), .mem_write_address(wa), .mem_write_data(wd), .mem_write_ready(wr),
        .preload_valid(pv), .preload_address(pa), .preload_data(pd), .busy(busy)
    );

    data_mem_responder #(.NUM_CONSUMERS(N), .ADDR_BITS(AB), .DATA_BITS(DB), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(rst_n),
        .mem_read_valid(rv0), .mem_read_address(ra0), .mem_read_ready(rr0), .mem_read_data(rd0),
        .mem_write_valid(wv0), .mem_write_address(wa0), .mem_write_data(wd0), .mem_write_ready(wr0),
        .preload_valid(pv0), .preload_address(pa0), .preload_data(pd0), .busy(busy0)
    );

    int checks = 0;
    int fails  = 0;

    typedef struct {
        int         lane;
        bit         is_wr;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    int         order_log[$];
    logic [7:0] model [256];
    logic [N-1:0] prev_rr = '0;
    logic [N-1:0] prev_wr = '0;
    int         hit;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: pops the scoreboard whenever a ready bit rises.
    always @(negedge clk) begin
        if (rst_n) begin
            if (|{rr, wr}) check("single_ready", ($countones({rr, wr}) <= 1) ? 32'd1 : 32'd0, 32'd1);
            for (int l = 0; l < N; l++) begin
                if (rr[l] && !prev_rr[l]) begin
                    hit = -1;
                    foreach (sb[k]) if (hit < 0 && sb[k].lane == l && !sb[k].is_wr) hit = k;
                    if (hit < 0) begin
                        check("unexpected_read_ready", 32'(l), 32'hFFFF);
                    end else begin
                        check("read_data", 32'(rd[l]), 32'(sb[hit].data));
                        sb.delete(hit);
                    end
                    order_log.push_back(l);
                end
                if (wr[l] && !prev_wr[l]) begin
                    hit = -1;
                    foreach (sb[k]) if (hit < 0 && sb[k].lane == l && sb[k].is_wr) hit = k;
                    check("write_expected", (hit >= 0) ? 32'd1 : 32'd0, 32'd1);
                    if (hit >= 0) sb.delete(hit);
                    order_log.push_back(l);
                end
            end
        end
        prev_rr = rr;
        prev_wr = wr;
    end

    task automatic preload(logic [7:0] addr, logic [7:0] data);
        @(negedge clk);
        pv = 1'b1; pa = addr; pd = data;
        model[addr] = data;
        @(negedge clk);
        pv = 1'b0;
    endtask

    // exp_lat >= 0 also checks ready timing and the one-edge clear after valid drops.
    task automatic do_read(int l, logic [7:0] addr, int exp_lat);
        int n;
        sb.push_back('{lane: l, is_wr: 1'b0, data: model[addr]});
        ra[l] = addr;
        rv[l] = 1'b1;
        n = 0;
        while (!rr[l] && n < 200) begin @(negedge clk); n++; end
        if (!rr[l]) check("read_timeout", 32'(l), 32'hFFFF);
        if (exp_lat >= 0) check("read_latency", 32'(n), 32'(exp_lat));
        rv[l] = 1'b0;
        ra[l] = 8'($urandom);
        @(negedge clk);
        if (exp_lat >= 0) check("read_ready_clear", 32'(rr[l]), 32'd0);
        n = 0;
        while (rr[l] && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic do_write(int l, logic [7:0] addr, logic [7:0] data);
        int n;
        model[addr] = data;
        sb.push_back('{lane: l, is_wr: 1'b1, data: data});
        wa[l] = addr;
        wd[l] = data;
        wv[l] = 1'b1;
        n = 0;
        while (!wr[l] && n < 200) begin @(negedge clk); n++; end
        if (!wr[l]) check("write_timeout", 32'(l), 32'hFFFF);
        wv[l] = 1'b0;
        wd[l] = 8'($urandom);
        n = 0;
        @(negedge clk);
        while (wr[l] && n < 200) begin @(negedge clk); n++; end
    endtask

    task automatic lane_random(int l);
        logic [7:0] addr;
        repeat (12) begin
            addr = {l[1:0], 6'($urandom)};
            if ($urandom_range(0, 1) == 1) do_write(l, addr, 8'($urandom));
            else                           do_read(l, addr, -1);
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
    endtask

    task automatic wait0(input bit want_write, output int n);
        n = 0;
        while (!(want_write ? wr0[0] : rr0[0]) && n < 50) begin @(negedge clk); n++; end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rv = '0; wv = '0; ra = '0; wa = '0; wd = '0; pv = 1'b0; pa = '0; pd = '0;
        rv0 = '0; wv0 = '0; ra0 = '0; wa0 = '0; wd0 = '0; pv0 = 1'b0; pa0 = '0; pd0 = '0;
        for (int i = 0; i < 256; i++) model[i] = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("reset_ready", 32'({rr, wr}), 32'd0);
        check("reset_read_data", 32'(|rd), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) preload(8'(i), 8'($urandom));
        preload(8'h00, 8'h11); preload(8'h01, 8'h22); preload(8'h02, 8'h33); preload(8'h03, 8'h44);
        preload(8'h10, 8'hA5); preload(8'h05, 8'h09);

        // All four lanes at once with the pointer at 0.
        @(negedge clk);
        order_log.delete();
        fork
            do_read(0, 8'h00, -1);
            do_read(1, 8'h01, -1);
            do_read(2, 8'h02, -1);
            do_read(3, 8'h03, -1);
        join
        check("all_lanes_count", 32'(order_log.size()), 32'd4);
        for (int i = 0; i < 4; i++) if (i < order_log.size()) check("all_lanes_order", 32'(order_log[i]), 32'(i));
        check("lane2_data_kept", 32'(rd[2]), 32'h33);

        do_read(0, 8'h10, 4);
        check("busy_after_read", 32'(busy), 32'd0);

        do_write(2, 8'h20, 8'h3C);
        do_read(1, 8'h20, -1);
        check("lane1_data", 32'(rd[1]), 32'h3C);

        // Pointer sits at 2 after the lane-1 grant: lane 3 wins over lane 0.
        order_log.delete();
        fork
            do_read(0, 8'h01, -1);
            do_read(3, 8'h02, -1);
        join
        check("rr_count", 32'(order_log.size()), 32'd2);
        if (order_log.size() == 2) begin
            check("rr_first", 32'(order_log[0]), 32'd3);
            check("rr_second", 32'(order_log[1]), 32'd0);
        end

        // Valid dropped right after grant: one-cycle ready pulse.
        sb.push_back('{lane: 1, is_wr: 1'b0, data: model[8'h03]});
        ra[1] = 8'h03; rv[1] = 1'b1;
        @(negedge clk);
        rv[1] = 1'b0; ra[1] = 8'h00;
        n = 0;
        while (!rr[1] && n < 50) begin @(negedge clk); n++; end
        check("early_drop_ready", 32'(rr[1]), 32'd1);
        @(negedge clk);
        check("early_drop_clear", 32'(rr[1]), 32'd0);

        // Reset in WAIT of a write abandons it.
        wa[0] = 8'h05; wd[0] = 8'h77; wv[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("busy_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midreset_ready", 32'({rr, wr}), 32'd0);
        check("midreset_read_data", 32'(|rd), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        wv[0] = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_read(0, 8'h05, -1);
        check("abandoned_write", 32'(rd[0]), 32'h09);

        fork
            lane_random(0);
            lane_random(1);
            lane_random(2);
            lane_random(3);
        join
        repeat (3) @(negedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        // LATENCY=0 instance: read-then-write from one lane.
        @(negedge clk);
        pv0 = 1'b1; pa0 = 8'h08; pd0 = 8'h5A;
        @(negedge clk);
        pv0 = 1'b0;
        ra0[0] = 8'h08; wa0[0] = 8'h08; wd0[0] = 8'h99;
        rv0[0] = 1'b1; wv0[0] = 1'b1;
        wait0(1'b0, n);
        check("l0_read_latency", 32'(n), 32'd2);
        check("l0_read_first", 32'(rd0[0]), 32'h5A);
        check("l0_write_not_yet", 32'(wr0[0]), 32'd0);
        rv0[0] = 1'b0;
        wait0(1'b1, n);
        check("l0_write_done", 32'(wr0[0]), 32'd1);
        check("l0_read_data_held", 32'(rd0[0]), 32'h5A);
        wv0[0] = 1'b0;
        @(negedge clk);
        check("l0_write_clear", 32'(wr0[0]), 32'd0);
        rv0[0] = 1'b1;
        wait0(1'b0, n);
        check("l0_readback", 32'(rd0[0]), 32'h99);
        rv0[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("l0_idle", 32'({rr0, wr0, busy0}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
